// File: rtl/brick_arith_pkg.sv
// Shared types and constants for the arithmetic-unit bricks (divider FSM states, counter sizing).
package brick_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Bits needed to hold an iteration count of 0..w
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  // Quotient reported for a zero divisor; truncated to the operand width by the user
  localparam logic [63:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/brick_divider_seq_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             in_bit,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next_c,
  output logic             q_bit_c
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem < dvs always holds, so the (WIDTH+1)-bit difference cannot wrap and its MSB is the sign
  always_comb begin
    shifted    = {rem, in_bit};
    trial      = shifted - {1'b0, dvs};
    q_bit_c    = ~trial[WIDTH];
    rem_next_c = q_bit_c ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/brick_divider_seq.sv
// Iterative radix-2 restoring divider, signed (truncating) or unsigned, valid/ready on both sides.
// Optional BRICK_DIVIDER_EARLY_OUT_EN: skip iteration when |divisor| > |dividend|.
module brick_divider_seq
  import brick_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = cnt_width(WIDTH);

  div_state_e       state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             signed_q, signed_d;
  logic             dvd_neg_q, dvd_neg_d;
  logic             dvs_neg_q, dvs_neg_d;
  logic [WIDTH-1:0] quotient_d, remainder_d;
  logic             dz_d, in_ready_d, out_valid_d;

  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] q_final;

  // acc_q shifts dividend bits out of the MSB while quotient bits enter at the LSB
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem        (rem_q),
    .in_bit     (acc_q[WIDTH-1]),
    .dvs        (dvs_q),
    .rem_next_c (step_rem),
    .q_bit_c    (step_q)
  );

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    rem_d       = rem_q;
    acc_d       = acc_q;
    dvs_d       = dvs_q;
    signed_d    = signed_q;
    dvd_neg_d   = dvd_neg_q;
    dvs_neg_d   = dvs_neg_q;
    quotient_d  = quotient;
    remainder_d = remainder;
    dz_d        = div_by_zero;

    dvd_mag = (is_signed && dividend[WIDTH-1]) ? (~dividend + WIDTH'(1)) : dividend;
    dvs_mag = (is_signed && divisor[WIDTH-1])  ? (~divisor + WIDTH'(1))  : divisor;
    q_final = {acc_q[WIDTH-2:0], step_q};

    case (state)
      IDLE: begin
        if (in_valid) begin
          signed_d  = is_signed;
          dvd_neg_d = dividend[WIDTH-1];
          dvs_neg_d = divisor[WIDTH-1];
          rem_d     = '0;
          acc_d     = dvd_mag;
          dvs_d     = dvs_mag;
          cnt_d     = CW'(WIDTH);
          dz_d      = 1'b0;
          if (divisor == '0) begin
            quotient_d  = WIDTH'(DIV0_QUOTIENT);
            remainder_d = dividend;
            dz_d        = 1'b1;
            state_d     = DONE;
          end
`ifdef BRICK_DIVIDER_EARLY_OUT_EN
          else if (dvs_mag > dvd_mag) begin
            quotient_d  = '0;
            remainder_d = dividend;
            state_d     = DONE;
          end
`endif
          else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        acc_d = q_final;
        cnt_d = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          // MIN / -1 wraps back to MIN here with no flag
          quotient_d  = (signed_q && (dvd_neg_q ^ dvs_neg_q)) ? (~q_final + WIDTH'(1)) : q_final;
          remainder_d = (signed_q && dvd_neg_q) ? (~step_rem + WIDTH'(1)) : step_rem;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rem_q       <= '0;
      acc_q       <= '0;
      dvs_q       <= '0;
      signed_q    <= 1'b0;
      dvd_neg_q   <= 1'b0;
      dvs_neg_q   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      rem_q       <= rem_d;
      acc_q       <= acc_d;
      dvs_q       <= dvs_d;
      signed_q    <= signed_d;
      dvd_neg_q   <= dvd_neg_d;
      dvs_neg_q   <= dvs_neg_d;
      quotient    <= quotient_d;
      remainder   <= remainder_d;
      div_by_zero <= dz_d;
      in_ready    <= in_ready_d;
      out_valid   <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_brick_divider_seq.sv
// Directed + random bench for brick_divider_seq (WIDTH=8) with an expected-result queue.
module tb_brick_divider_seq;

  localparam int NORM_LAT = 9;
`ifdef BRICK_DIVIDER_EARLY_OUT_EN
  localparam int EO_LAT = 1;
`else
  localparam int EO_LAT = 9;
`endif

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       is_signed;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  brick_divider_seq #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .is_signed   (is_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  function automatic logic [7:0] mag(input logic [7:0] x, input logic s);
    return (s && x[7]) ? 8'(-x) : x;
  endfunction

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic s);
    exp_t e;
    int sa, sb_;
    if (b == 8'd0) begin
      e = '{8'hFF, a, 1'b1, 1};
    end else begin
      if (s) begin
        sa  = int'($signed(a));
        sb_ = int'($signed(b));
        e.q = 8'(sa / sb_);
        e.r = 8'(sa % sb_);
      end else begin
        e.q = a / b;
        e.r = a % b;
      end
      e.dz  = 1'b0;
      e.lat = NORM_LAT;
`ifdef BRICK_DIVIDER_EARLY_OUT_EN
      if (mag(b, s) > mag(a, s)) e.lat = 1;
`endif
    end
    return e;
  endfunction

  // Handshake one operand pair; leaves the bench #1 after the accept edge
  task automatic drive_accept(input logic [7:0] a, input logic [7:0] b, input logic s);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
  endtask

  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic s, input exp_t e);
    sb.push_back(e);
    drive_accept(a, b, s);
  endtask

  task automatic finish_op(input string tag);
    int   lat = 1;
    exp_t e;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_quotient"}, 32'(quotient), 32'(e.q));
      check({tag, "_remainder"}, 32'(remainder), 32'(e.r));
      check({tag, "_div_by_zero"}, 32'(div_by_zero), 32'(e.dz));
      check({tag, "_latency"}, 32'(lat), 32'(e.lat));
    end
    if (out_ready) begin
      @(posedge clk); #1;
      check({tag, "_released"}, {30'd0, out_valid, in_ready}, 32'b01);
    end
  endtask

  initial begin
    logic [7:0] hq, hr;
    logic       saw_valid;
    logic [7:0] ra, rb;
    logic       rs;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    is_signed = 1'b0;
    out_ready = 1'b1;

    #12;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_quotient", 32'(quotient), 32'd0);
    check("reset_remainder", 32'(remainder), 32'd0);
    check("reset_dz", 32'(div_by_zero), 32'd0);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    start_op(8'd200, 8'd7, 1'b0, '{8'd28, 8'd4, 1'b0, NORM_LAT});
    finish_op("u200_7");

    start_op(8'hF9, 8'h02, 1'b1, '{8'hFD, 8'hFF, 1'b0, NORM_LAT});
    finish_op("s_m7_2");

    start_op(8'h07, 8'hFE, 1'b1, '{8'hFD, 8'h01, 1'b0, NORM_LAT});
    finish_op("s_7_m2");

    start_op(8'h55, 8'h00, 1'b0, '{8'hFF, 8'h55, 1'b1, 1});
    finish_op("div0");

    start_op(8'd200, 8'd7, 1'b0, '{8'd28, 8'd4, 1'b0, NORM_LAT});
    finish_op("dz_cleared");

    start_op(8'h80, 8'hFF, 1'b1, '{8'h80, 8'h00, 1'b0, NORM_LAT});
    finish_op("s_min_m1");

    start_op(8'd3, 8'd10, 1'b0, '{8'd0, 8'd3, 1'b0, EO_LAT});
    finish_op("u3_10");

    start_op(8'hFD, 8'd10, 1'b1, '{8'd0, 8'hFD, 1'b0, EO_LAT});
    finish_op("s_m3_10");

    // Backpressure: result must hold and new operands must be ignored
    out_ready = 1'b0;
    start_op(8'd100, 8'd9, 1'b0, '{8'd11, 8'd1, 1'b0, NORM_LAT});
    finish_op("bp");
    hq = quotient;
    hr = remainder;
    for (int i = 0; i < 5; i++) begin
      dividend = 8'd250;
      divisor  = 8'd3;
      in_valid = 1'b1;
      @(posedge clk); #1;
      check("bp_hold", {14'd0, out_valid, in_ready, quotient, remainder}, {14'd0, 1'b1, 1'b0, hq, hr});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", {30'd0, out_valid, in_ready}, 32'b01);

    start_op(8'd50, 8'd6, 1'b0, '{8'd8, 8'd2, 1'b0, NORM_LAT});
    finish_op("after_bp");

    // Reset in the middle of CALC aborts the division
    drive_accept(8'd200, 8'd7, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    check("rst_mid_no_result", 32'(saw_valid), 32'd0);

    for (int i = 0; i < 12; i++) begin
      ra = 8'($urandom);
      rb = (i == 5) ? 8'd0 : 8'($urandom);
      rs = 1'($urandom);
      start_op(ra, rb, rs, model(ra, rb, rs));
      finish_op($sformatf("rand%0d", i));
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
